sum_window_acc: RTL and testbench
=================================

// Module: sum_window_acc
//
// PURPOSE
//   Downstream consumer of the registered adder result stream.
//   Accepts 8-bit sums over a valid/ready handshake and accumulates them over a fixed window of WINDOW samples.
//   Per window it produces the exact total, the average and the maximum sample.
//   The result is held under output backpressure until the next stage accepts it.
//
// PARAMETERS
//   DW      8   width of input sample (matches adder output width)
//   WINDOW  4   samples per window; power of two, >= 2
//   LW      $clog2(WINDOW), derived (localparam); SW = DW+LW = width of out_sum
//
// PORTS
//   clk        in   1   clock, all logic on posedge
//   aresetn    in   1   asynchronous reset, active low
//   clr        in   1   sync abort of the partial window
//   in_valid   in   1   in_data valid
//   in_ready   out  1   block can accept a sample
//   in_data    in   DW  sample (adder result)
//   out_valid  out  1   window result valid
//   out_ready  in   1   downstream accepts result
//   out_sum    out  SW  sum of WINDOW samples
//   out_avg    out  DW  out_sum >> LW (truncating)
//   out_max    out  DW  largest sample in window
//
// BEHAVIOUR
//   - Reset (aresetn=0, async):
//     - state=ACC; acc, cnt, max cleared.
//     - out_valid/out_sum/out_avg/out_max = 0.
//     - in_ready forced 0 while aresetn=0.
//     - Reset mid-window discards partial data and any pending result.
//   - FSM states ACC and HOLD:
//     - in_ready = (state==ACC) && !clr; combinational, never depends on out_ready.
//   - ACC, transfer (in_valid && in_ready):
//     - acc += in_data; max = max(max, in_data); cnt++.
//   - Window completion: transfer with cnt==WINDOW-1.
//     - Next edge: out_sum = acc+in_data, out_max updated, out_valid=1, state=HOLD.
//     - acc, cnt, max cleared.
//     - Latency: result visible 1 cycle after last accepted sample.
//   - HOLD:
//     - in_ready=0; out_* stable while out_valid && !out_ready.
//     - On out_valid && out_ready: out_valid=0, state=ACC at next edge.
//     - out_sum/avg/max keep their last value after acceptance.
//   - Throughput: at most WINDOW samples per WINDOW+1 cycles (one bubble per window).
//   - Arithmetic: acc is SW bits, exact; no overflow possible (WINDOW*(2^DW-1) < 2^SW).
//   - clr in ACC: clears acc, cnt, max.
//     - A coincident in_valid is NOT consumed (in_ready=0 that cycle).
//   - clr in HOLD: no effect on the pending result or the FSM.
//   - in_valid gaps (idle cycles) between samples are legal; no timeout.
//   - Input values are unconstrained; X on in_data is ignored when in_valid=0.
//
// TESTING (DW=8, WINDOW=4)
//   1. 10,10,10,10 back-to-back, out_ready=1 -> out_sum=40, out_avg=10, out_max=10; out_valid 1 cycle after 4th accept, 1 cycle wide.
//   2. 255 x4 -> out_sum=1020, out_avg=255, out_max=255 (no wrap).
//   3. 1,9,3,7, out_ready=0 for 5 cycles -> out_valid held, in_ready=0, outputs stable (sum 20, avg 5, max 9); out_ready=1 -> in_ready=1 next cycle.
//   4. 3,7 then clr (with in_valid=1, data 99 not taken) then 1,2,3,4 -> out_sum=10, out_avg=2, out_max=4.
//   5. 6,6,6 then aresetn pulse low mid-cycle -> all outputs 0 immediately; then 5,5,5,5 -> out_sum=20.
//   6. random 0..10 samples with random in_valid gaps and out_ready stalls, 200 windows -> scoreboard sum/avg/max match, no lost or duplicated samples.

Source files
------------

// File: rtl/sum_window_acc_if.sv
// Handshake bundle between the adder result stream, the window accumulator and its consumer.
// Slave is the accumulator's view of the bundle; master is the side driving samples and taking results.
interface sum_window_acc_if #(
    parameter int DW     = 8,
    parameter int WINDOW = 4
);
    localparam int LW = $clog2(WINDOW);
    localparam int SW = DW + LW;

    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_data;
    logic          out_valid;
    logic          out_ready;
    logic [SW-1:0] out_sum;
    logic [DW-1:0] out_avg;
    logic [DW-1:0] out_max;

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_sum, out_avg, out_max
    );

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_sum, out_avg, out_max
    );
endinterface

// File: rtl/sum_window_acc.sv
// Accumulates WINDOW samples and reports their exact sum, truncated average and maximum.
// The result is held in HOLD until it is accepted; input is stalled during that time.
module sum_window_acc #(
    parameter int DW     = 8,
    parameter int WINDOW = 4
) (
    input  logic              clk,
    input  logic              aresetn,
    input  logic              clr,
    sum_window_acc_if.slave   bus
);
    localparam int LW = $clog2(WINDOW);
    localparam int SW = DW + LW;

    typedef enum logic {ACC, HOLD} state_e;

    state_e        state_q, state_d;
    logic [SW-1:0] acc_q, acc_d;
    logic [LW-1:0] cnt_q, cnt_d;
    logic [DW-1:0] max_q, max_d;
    logic          out_valid_q, out_valid_d;
    logic [SW-1:0] out_sum_q, out_sum_d;
    logic [DW-1:0] out_avg_q, out_avg_d;
    logic [DW-1:0] out_max_q, out_max_d;

    logic          take;
    logic [SW-1:0] sum_nxt;
    logic [DW-1:0] max_nxt;

    // Ready is held low while reset is asserted even though the state already reads ACC.
    assign bus.in_ready  = aresetn && (state_q == ACC) && !clr;
    assign bus.out_valid = out_valid_q;
    assign bus.out_sum   = out_sum_q;
    assign bus.out_avg   = out_avg_q;
    assign bus.out_max   = out_max_q;

    assign take = bus.in_valid && bus.in_ready;

    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        max_d       = max_q;
        out_valid_d = out_valid_q;
        out_sum_d   = out_sum_q;
        out_avg_d   = out_avg_q;
        out_max_d   = out_max_q;
        sum_nxt     = acc_q + SW'(bus.in_data);
        max_nxt     = (bus.in_data > max_q) ? bus.in_data : max_q;

        case (state_q)
            ACC: begin
                if (clr) begin
                    acc_d = '0;
                    cnt_d = '0;
                    max_d = '0;
                end else if (take) begin
                    if (cnt_q == LW'(WINDOW - 1)) begin
                        out_valid_d = 1'b1;
                        out_sum_d   = sum_nxt;
                        out_avg_d   = sum_nxt[SW-1:LW];
                        out_max_d   = max_nxt;
                        state_d     = HOLD;
                        acc_d       = '0;
                        cnt_d       = '0;
                        max_d       = '0;
                    end else begin
                        acc_d = sum_nxt;
                        cnt_d = cnt_q + LW'(1);
                        max_d = max_nxt;
                    end
                end
            end
            HOLD: begin
                // Result fields keep their value after acceptance; only valid drops.
                if (bus.out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = ACC;
                end
            end
            default: state_d = ACC;
        endcase
    end

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            state_q     <= ACC;
            acc_q       <= '0;
            cnt_q       <= '0;
            max_q       <= '0;
            out_valid_q <= 1'b0;
            out_sum_q   <= '0;
            out_avg_q   <= '0;
            out_max_q   <= '0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            max_q       <= max_d;
            out_valid_q <= out_valid_d;
            out_sum_q   <= out_sum_d;
            out_avg_q   <= out_avg_d;
            out_max_q   <= out_max_d;
        end
    end
endmodule

// File: tb/tb_sum_window_acc.sv
// Bench for sum_window_acc: vector table, hand-written corner sequences and a randomized
// run against a queue-based window model.
module tb_sum_window_acc;
    localparam int DW     = 8;
    localparam int WINDOW = 4;

    typedef struct {
        logic [3:0][7:0] s;
        int              sum;
        int              avg;
        int              mx;
    } vec_t;

    typedef struct {
        int sum;
        int avg;
        int mx;
    } res_t;

    logic clk = 1'b0;
    logic aresetn;
    logic clr;

    sum_window_acc_if #(.DW(DW), .WINDOW(WINDOW)) bus();

    sum_window_acc #(.DW(DW), .WINDOW(WINDOW)) dut (
        .clk     (clk),
        .aresetn (aresetn),
        .clr     (clr),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge after the sample was taken.
    task automatic send(input logic [7:0] d);
        int t;
        t = 0;
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        #1;
        while (!bus.in_ready && t < 50) begin
            @(negedge clk);
            #1;
            t++;
        end
        if (!bus.in_ready) chk("send_timeout", 32'(bus.in_ready), 1);
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.in_data  = 'x;
    endtask

    task automatic chk_res(input string name, input int s, input int a, input int m);
        chk({name, "_valid"}, 32'(bus.out_valid), 1);
        chk({name, "_sum"},   32'(bus.out_sum),   s);
        chk({name, "_avg"},   32'(bus.out_avg),   a);
        chk({name, "_max"},   32'(bus.out_max),   m);
    endtask

    vec_t tbl [5];
    res_t exp_q [$];
    int   win [$];

    initial begin
        tbl[0] = '{s: {8'd10,  8'd10,  8'd10,  8'd10},  sum: 40,   avg: 10,  mx: 10};
        tbl[1] = '{s: {8'd255, 8'd255, 8'd255, 8'd255}, sum: 1020, avg: 255, mx: 255};
        tbl[2] = '{s: {8'd0,   8'd0,   8'd0,   8'd0},   sum: 0,    avg: 0,   mx: 0};
        tbl[3] = '{s: {8'd250, 8'd3,   8'd2,   8'd1},   sum: 256,  avg: 64,  mx: 250};
        tbl[4] = '{s: {8'd3,   8'd17,  8'd0,   8'd200}, sum: 220,  avg: 55,  mx: 200};

        aresetn       = 1'b1;
        clr           = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b1;
        #2 aresetn = 1'b0;
        @(negedge clk);
        chk("rst_out_valid", 32'(bus.out_valid), 0);
        chk("rst_in_ready",  32'(bus.in_ready),  0);
        chk("rst_out_sum",   32'(bus.out_sum),   0);
        chk("rst_out_max",   32'(bus.out_max),   0);
        repeat (2) @(negedge clk);
        aresetn = 1'b1;
        #1 chk("rst_rel_in_ready", 32'(bus.in_ready), 1);

        // Back-to-back windows with the consumer always ready.
        for (int i = 0; i < 5; i++) begin
            for (int j = 0; j < WINDOW; j++) send(tbl[i].s[j]);
            chk_res($sformatf("tbl%0d", i), tbl[i].sum, tbl[i].avg, tbl[i].mx);
            @(negedge clk);
            chk($sformatf("tbl%0d_pulse", i), 32'(bus.out_valid), 0);
        end

        // Backpressure: result held, input stalled.
        bus.out_ready = 1'b0;
        send(8'd1); send(8'd9); send(8'd3); send(8'd7);
        chk_res("bp", 20, 5, 9);
        repeat (5) begin
            @(negedge clk);
            #1;
            chk_res("bp_hold", 20, 5, 9);
            chk("bp_in_ready", 32'(bus.in_ready), 0);
        end
        bus.out_ready = 1'b1;
        @(negedge clk);
        #1;
        chk("bp_rel_in_ready",  32'(bus.in_ready),  1);
        chk("bp_rel_out_valid", 32'(bus.out_valid), 0);
        chk("bp_rel_keep_sum",  32'(bus.out_sum),   20);

        // clr drops the partial window and does not take the coincident sample.
        send(8'd3); send(8'd7);
        clr          = 1'b1;
        bus.in_valid = 1'b1;
        bus.in_data  = 8'd99;
        #1 chk("clr_in_ready", 32'(bus.in_ready), 0);
        @(negedge clk);
        clr          = 1'b0;
        bus.in_valid = 1'b0;
        send(8'd1); send(8'd2); send(8'd3); send(8'd4);
        chk_res("clr", 10, 2, 4);

        // Asynchronous reset mid-window.
        send(8'd6); send(8'd6); send(8'd6);
        #2 aresetn = 1'b0;
        #1;
        chk("arst_out_valid", 32'(bus.out_valid), 0);
        chk("arst_out_sum",   32'(bus.out_sum),   0);
        chk("arst_out_avg",   32'(bus.out_avg),   0);
        chk("arst_out_max",   32'(bus.out_max),   0);
        chk("arst_in_ready",  32'(bus.in_ready),  0);
        @(negedge clk);
        aresetn = 1'b1;
        send(8'd5); send(8'd5); send(8'd5); send(8'd5);
        chk_res("arst_after", 20, 5, 5);

        // Randomized traffic against a window model.
        begin
            int got, cyc;
            logic hold_prev;
            logic [31:0] sum_prev, avg_prev, max_prev;
            got = 0;
            cyc = 0;
            hold_prev = 1'b0;
            sum_prev = '0; avg_prev = '0; max_prev = '0;
            while (got < 200 && cyc < 20000) begin
                @(negedge clk);
                if (hold_prev) begin
                    chk("rnd_stable_valid", 32'(bus.out_valid), 1);
                    chk("rnd_stable_sum",   32'(bus.out_sum),   sum_prev);
                    chk("rnd_stable_avg",   32'(bus.out_avg),   avg_prev);
                    chk("rnd_stable_max",   32'(bus.out_max),   max_prev);
                end
                bus.in_valid  = ($urandom_range(0, 3) != 0);
                bus.in_data   = 8'($urandom_range(0, 10));
                bus.out_ready = ($urandom_range(0, 2) != 0);
                #1;
                hold_prev = bus.out_valid && !bus.out_ready;
                sum_prev  = 32'(bus.out_sum);
                avg_prev  = 32'(bus.out_avg);
                max_prev  = 32'(bus.out_max);
                if (bus.out_valid && bus.out_ready) begin
                    if (exp_q.size() == 0) begin
                        chk("rnd_unexpected_result", 1, 0);
                    end else begin
                        res_t e;
                        e = exp_q.pop_front();
                        chk("rnd_sum", 32'(bus.out_sum), e.sum);
                        chk("rnd_avg", 32'(bus.out_avg), e.avg);
                        chk("rnd_max", 32'(bus.out_max), e.mx);
                    end
                    got++;
                end
                if (bus.in_valid && bus.in_ready) begin
                    win.push_back(int'(bus.in_data));
                    if (win.size() == WINDOW) begin
                        res_t r;
                        r.sum = 0;
                        r.mx  = 0;
                        foreach (win[k]) begin
                            r.sum += win[k];
                            if (win[k] > r.mx) r.mx = win[k];
                        end
                        r.avg = r.sum / WINDOW;
                        exp_q.push_back(r);
                        win.delete();
                    end
                end
                cyc++;
            end
            chk("rnd_windows",  got, 200);
            chk("rnd_leftover", exp_q.size(), 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
